// File: rtl/mrfm_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module : mrfm_serial_pkg
// Brief  : Frame geometry, counter constants and FSM encoding for the MRFM
//          host serial master.
// Rev    : 1.0
// ============================================================================
package mrfm_serial_pkg;

  localparam int FRAME_BITS = 40;
  localparam int CMD_BITS   = 8;
  localparam int RW_BIT     = FRAME_BITS - 1;
  localparam int CNT_W      = 6;

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_CMD      = CNT_W'(CMD_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST_CMD = CNT_W'(CMD_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_WDATA  = 3'd2;
  localparam logic [2:0] ST_RDATA  = 3'd3;
  localparam logic [2:0] ST_COMMIT = 3'd4;

endpackage
`default_nettype wire

// File: rtl/mrfm_sync_edge.sv
`default_nettype none
// ============================================================================
// Module : mrfm_sync_edge
// Brief  : N-stage synchronizer for an asynchronous level with single-clock
//          rise/fall pulses derived from the synchronized value.
// Rev    : 1.0
// ============================================================================
module mrfm_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o =  sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule
`default_nettype wire

// File: rtl/mrfm_serial_master.sv
`default_nettype none
// ============================================================================
// Module : mrfm_serial_master
// Brief  : Host 3-wire serial front end driving the setting bus, with
//          readback serialization for read frames.
// Rev    : 1.0
// ============================================================================
module mrfm_serial_master
  import mrfm_serial_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ser_enable,
  input  logic              ser_sclk,
  input  logic              ser_sdi,
  output logic              ser_sdo,
  output logic              ser_sdo_oe,
  output logic              serial_strobe,
  output logic [ADDR_W-1:0] serial_addr,
  output logic [DATA_W-1:0] serial_data,
  output logic [ADDR_W-1:0] readback_addr,
  input  logic [DATA_W-1:0] readback_data,
  output logic              frame_error
);

  localparam int SHIFT_W = ADDR_W + DATA_W;
  // Position of the R/W bit inside the shift register once the command byte is in
  localparam int RW_POS  = RW_BIT - (FRAME_BITS - CMD_BITS);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_stages
    $error("mrfm_serial_master: SYNC_STAGES must be 2 or 3");
  end
  if (1 + SHIFT_W != FRAME_BITS) begin : g_bad_frame
    $error("mrfm_serial_master: 1 + ADDR_W + DATA_W must equal FRAME_BITS");
  end

  logic                   en_rise, en_fall, sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic                   sdi_s;

  mrfm_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_en (
    .clock  (clock),
    .reset  (reset),
    .d_i    (ser_enable),
    .rise_o (en_rise),
    .fall_o (en_fall)
  );

  mrfm_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clock  (clock),
    .reset  (reset),
    .d_i    (ser_sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sdi_sync_q <= '0;
    else        sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], ser_sdi};
  end
  assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

  logic [2:0]         state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [SHIFT_W-1:0] shift_q,   shift_d;
  logic [1:0]         rd_pipe_q, rd_pipe_d;
  logic [DATA_W-1:0]  sdo_sr_q,  sdo_sr_d;
  logic               oe_q,      oe_d;
  logic               strobe_q,  strobe_d;
  logic [ADDR_W-1:0]  addr_q,    addr_d;
  logic [DATA_W-1:0]  data_q,    data_d;
  logic [ADDR_W-1:0]  rb_addr_q, rb_addr_d;
  logic               ferr_q,    ferr_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    rd_pipe_d = {rd_pipe_q[0], 1'b0};
    sdo_sr_d  = sdo_sr_q;
    oe_d      = oe_q;
    strobe_d  = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    rb_addr_d = rb_addr_q;
    ferr_d    = ferr_q;

    if (en_rise) begin
      // A rise outside IDLE means the previous frame never closed cleanly
      state_d   = ST_CMD;
      cnt_d     = '0;
      rd_pipe_d = '0;
      oe_d      = 1'b0;
      sdo_sr_d  = '0;
      if (state_q != ST_IDLE) ferr_d = 1'b1;
    end else if (en_fall) begin
      state_d   = ST_COMMIT;
      rd_pipe_d = '0;
      if (cnt_q == CNT_FULL && state_q == ST_WDATA) begin
        strobe_d = 1'b1;
        addr_d   = shift_q[SHIFT_W-1 -: ADDR_W];
        data_d   = shift_q[DATA_W-1:0];
        ferr_d   = 1'b0;
      end else if (cnt_q == CNT_FULL && state_q == ST_RDATA) begin
        ferr_d   = 1'b0;
      end else begin
        ferr_d   = 1'b1;
      end
    end else begin
      case (state_q)
        ST_CMD: begin
          if (sclk_rise) begin
            shift_d = {shift_q[SHIFT_W-2:0], sdi_s};
            cnt_d   = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST_CMD) begin
              if (shift_d[RW_POS]) begin
                state_d      = ST_RDATA;
                rb_addr_d    = shift_d[ADDR_W-1:0];
                rd_pipe_d[0] = 1'b1;
              end else begin
                state_d      = ST_WDATA;
              end
            end
          end
        end
        ST_WDATA: begin
          if (sclk_rise && cnt_q != CNT_FULL) begin
            shift_d = {shift_q[SHIFT_W-2:0], sdi_s};
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        ST_RDATA: begin
          if (sclk_rise && cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_ONE;
          // The fall that closes the command byte must not shift: bit 31 is
          // still waiting for the host's first data-phase rise.
          if (sclk_fall && cnt_q > CNT_CMD) sdo_sr_d = {sdo_sr_q[DATA_W-2:0], 1'b0};
          if (rd_pipe_q[1]) begin
            sdo_sr_d = readback_data;
            oe_d     = 1'b1;
          end
        end
        ST_COMMIT: begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          oe_d     = 1'b0;
          sdo_sr_d = '0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      rd_pipe_q <= '0;
      sdo_sr_q  <= '0;
      oe_q      <= 1'b0;
      strobe_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rb_addr_q <= '0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      rd_pipe_q <= rd_pipe_d;
      sdo_sr_q  <= sdo_sr_d;
      oe_q      <= oe_d;
      strobe_q  <= strobe_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rb_addr_q <= rb_addr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign ser_sdo       = sdo_sr_q[DATA_W-1];
  assign ser_sdo_oe    = oe_q;
  assign serial_strobe = strobe_q;
  assign serial_addr   = addr_q;
  assign serial_data   = data_q;
  assign readback_addr = rb_addr_q;
  assign frame_error   = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_mrfm_serial_master.sv
`default_nettype none
// ============================================================================
// Module : tb_mrfm_serial_master
// Brief  : Scoreboard bench: host frames push expected bus writes, a monitor
//          pops them on every serial_strobe.
// Rev    : 1.0
// ============================================================================
module tb_mrfm_serial_master;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              ser_enable = 1'b0;
  logic              ser_sclk = 1'b0;
  logic              ser_sdi = 1'b0;
  logic              ser_sdo, ser_sdo_oe, serial_strobe, frame_error;
  logic [ADDR_W-1:0] serial_addr, readback_addr;
  logic [DATA_W-1:0] serial_data, readback_data;

  logic [DATA_W-1:0] rb_mem [0:127];
  assign readback_data = rb_mem[readback_addr];

  mrfm_serial_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .ser_enable    (ser_enable),
    .ser_sclk      (ser_sclk),
    .ser_sdi       (ser_sdi),
    .ser_sdo       (ser_sdo),
    .ser_sdo_oe    (ser_sdo_oe),
    .serial_strobe (serial_strobe),
    .serial_addr   (serial_addr),
    .serial_data   (serial_data),
    .readback_addr (readback_addr),
    .readback_data (readback_data),
    .frame_error   (frame_error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  // Reference state of the bus as seen from the host side
  logic [6:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [6:0]  m_rb   = '0;
  logic        m_ferr = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (serial_strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got strobe addr %0h data %0h expected none",
                 serial_addr, serial_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_addr", 64'(serial_addr), 64'(mon_e.addr));
        check("strobe_data", 64'(serial_data), 64'(mon_e.data));
        check("strobe_latency", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobe"}, 64'(serial_strobe), 64'd0);
    check({tag, "_addr"},   64'(serial_addr),   64'd0);
    check({tag, "_data"},   64'(serial_data),   64'd0);
    check({tag, "_rbaddr"}, 64'(readback_addr), 64'd0);
    check({tag, "_sdo"},    64'({ser_sdo, ser_sdo_oe}), 64'd0);
    check({tag, "_ferr"},   64'(frame_error),   64'd0);
  endtask

  // Drives one host frame of nbits sclk pulses; rst_at >= 0 resets mid-frame.
  task automatic send_frame(input logic rw, input logic [6:0] addr, input logic [31:0] data,
                            input int nbits, input int idle, input int rst_at);
    logic [39:0] fr;
    logic [31:0] cap;
    logic        oe_ok;
    exp_t        e;
    fr    = {rw, addr, data};
    cap   = '0;
    oe_ok = 1'b1;
    ser_enable = 1'b1;
    clk_wait(4);
    for (int i = 0; i < nbits; i++) begin
      ser_sdi = (i < 40) ? fr[39-i] : 1'($urandom);
      clk_wait(4);
      if (i >= 8 && i < 40) begin
        cap = {cap[30:0], ser_sdo};
        if (ser_sdo_oe !== 1'b1) oe_ok = 1'b0;
      end
      ser_sclk = 1'b1;
      if (i == rst_at) begin
        #3 reset = 1'b0;
        #1 check_all_zero("async_reset");
        ser_enable = 1'b0;
        ser_sclk   = 1'b0;
        @(negedge clock);
        clk_wait(3);
        reset  = 1'b1;
        m_addr = '0;
        m_data = '0;
        m_rb   = '0;
        m_ferr = 1'b0;
        clk_wait(4);
        return;
      end
      clk_wait(4);
      ser_sclk = 1'b0;
    end
    clk_wait(4);
    if (!rw && nbits >= 40) begin
      e.addr = addr;
      e.data = data;
      e.cyc  = 32'(cyc + 3);
      exp_q.push_back(e);
    end
    ser_enable = 1'b0;
    if (nbits >= 40) begin
      m_ferr = 1'b0;
      if (!rw) begin
        m_addr = addr;
        m_data = data;
      end
    end else begin
      m_ferr = 1'b1;
    end
    if (rw && nbits >= 8) m_rb = addr;
    if (rw && nbits >= 40) begin
      check("rd_word", 64'(cap), 64'(rb_mem[addr]));
      check("rd_oe_during_data", 64'(oe_ok), 64'd1);
    end
    clk_wait(idle);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_ferr"},   64'(frame_error),   64'(m_ferr));
    check({tag, "_addr"},   64'(serial_addr),   64'(m_addr));
    check({tag, "_data"},   64'(serial_data),   64'(m_data));
    check({tag, "_rbaddr"}, 64'(readback_addr), 64'(m_rb));
    check({tag, "_oe_idle"}, 64'({ser_sdo_oe, ser_sdo}), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rw;
    logic [6:0]  a;
    logic [31:0] d;
    int          nb;
    for (int i = 0; i < 128; i++) rb_mem[i] = $urandom;
    rb_mem[7'h41] = 32'hA5A5_0F0F;

    clk_wait(3);
    check_all_zero("reset");
    reset = 1'b1;
    clk_wait(4);

    send_frame(1'b0, 7'h40, 32'h0012_3456, 40, 8, -1);
    check_state("wr40");
    send_frame(1'b1, 7'h41, 32'hDEAD_BEEF, 40, 8, -1);
    check_state("rd41");
    send_frame(1'b0, 7'h22, 32'h1111_2222, 39, 8, -1);
    check_state("trunc39");
    send_frame(1'b0, 7'h23, 32'h3333_4444, 40, 8, -1);
    check_state("good_after_trunc");
    send_frame(1'b0, 7'h15, 32'hCAFE_F00D, 45, 8, -1);
    check_state("over45");
    send_frame(1'b0, 7'h16, 32'h0BAD_0BAD, 0, 8, -1);
    check_state("zero_bits");
    send_frame(1'b0, 7'h17, 32'h7777_8888, 40, 8, 20);
    check_state("after_reset");
    send_frame(1'b0, 7'h18, 32'h9999_AAAA, 40, 8, -1);
    check_state("post_reset_frame");
    send_frame(1'b0, 7'h40, 32'h0101_0101, 40, 4, -1);
    send_frame(1'b0, 7'h41, 32'h0202_0202, 40, 8, -1);
    check_state("back_to_back");

    for (int k = 0; k < 16; k++) begin
      rw = 1'($urandom_range(0, 1));
      a  = 7'($urandom);
      d  = $urandom;
      nb = ($urandom_range(0, 3) < 2) ? 40 : int'($urandom_range(0, 45));
      send_frame(rw, a, d, nb, 8, -1);
      check_state($sformatf("rand%0d", k));
    end

    clk_wait(10);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
